// File: rtl/apb_master_bridge.sv
// Request FIFO feeding an APB master: queued {write, addr, wdata} entries are issued
// in order as SETUP/ACCESS transfers, each completing with a one-cycle response pulse.
module apb_master_bridge #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    input  logic        pready,
    input  logic [31:0] prdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] WAIT_ONE  = TW'(1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    logic [64:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    state_t        state_q, state_d;
    logic          psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [31:0]   paddr_q, paddr_d, pwdata_q, pwdata_d;
    logic          rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d, rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          push, pop, empty, load;
    logic [64:0]   head;

    assign req_ready = (count_q != FULL_CNT);
    assign push      = req_valid && req_ready;
    assign empty     = (count_q == '0);
    assign head      = fifo_mem[rd_ptr_q];

    always_ff @(posedge pclk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {req_write, req_addr, req_wdata};
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        load        = 1'b0;
        pop         = 1'b0;

        case (state_q)
            IDLE: load = !empty;
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // A timeout ends the transfer exactly like a completion, flagged as an error.
                if (pready || (wait_cnt_q == LAST_WAIT)) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = pwrite_q;
                    rsp_err_d   = !pready;
                    rsp_rdata_d = (pready && !pwrite_q) ? prdata : '0;
                    load        = !empty;
                    if (empty) begin
                        state_d   = IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            pop        = 1'b1;
            state_d    = SETUP;
            psel_d     = 1'b1;
            penable_d  = 1'b0;
            pwrite_d   = head[64];
            paddr_d    = head[63:32];
            pwdata_d   = head[31:0];
            wait_cnt_d = '0;
        end

        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wait_cnt_q  <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wait_cnt_q  <= wait_cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: directed requests push expected responses and
// APB setups into queues; negedge monitors pop and compare; the slave stalls by address.
module tb_apb_master_bridge;

    logic        pclk, rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_write, rsp_err;
    logic [31:0] rsp_rdata, paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready;

    apb_master_bridge #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .pclk(pclk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .paddr(paddr), .pwdata(pwdata), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pready(pready), .prdata(prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic        w;
        logic        err;
        logic [31:0] rd;
        int          lat;   // accept edge -> response edge, -1 = not checked
        int          gap;   // previous response edge -> this one, -1 = not checked
        int          acc;
    } rsp_t;
    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } apb_t;

    rsp_t rsp_q[$];
    apb_t apb_q[$];
    apb_t cur;
    int   n_cmp = 0, n_fail = 0, cycle = 0, last_rsp = 0, n_rsp = 0;

    always @(posedge pclk) cycle <= cycle + 1;

    // Slave model: memory preset to mem[i]=i, wait states chosen by address.
    logic [31:0] slave_mem [128];
    int          acc_cnt;

    function automatic int wait_of(input logic [31:0] a);
        case (a)
            32'h20:        return 3;
            32'h40:        return 10;
            32'h30, 32'h50: return 1000;
            default:       return 0;
        endcase
    endfunction

    always_comb pready = (acc_cnt >= wait_of(paddr));
    assign prdata = slave_mem[paddr[6:0]];

    always @(posedge pclk) begin
        if (!rst_n || !(psel && penable) || pready) acc_cnt <= 0;
        else acc_cnt <= acc_cnt + 1;
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) slave_mem[i] <= i;
        end else if (psel && penable && pready && pwrite) begin
            slave_mem[paddr[6:0]] <= pwdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", name, cycle);
    endtask

    // Monitors: response scoreboard and APB phase checker.
    always @(negedge pclk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    n_rsp++;
                    $display("rsp %0d @%0d: write=%0b err=%0b rdata=0x%08h", n_rsp, cycle,
                             rsp_write, rsp_err, rsp_rdata);
                    check("rsp_write", 32'(rsp_write), 32'(e.w));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_rdata", rsp_rdata, e.rd);
                    if (e.lat >= 0) check("rsp_latency", 32'(cycle - e.acc), 32'(e.lat));
                    if (e.gap >= 0) check("rsp_gap", 32'(cycle - last_rsp), 32'(e.gap));
                end
                last_rsp = cycle;
            end
            if (psel && !penable) begin
                if (apb_q.size() == 0) begin
                    fail_now("unexpected_setup");
                end else begin
                    cur = apb_q.pop_front();
                    check("setup_pwrite", 32'(pwrite), 32'(cur.w));
                    check("setup_paddr", paddr, cur.a);
                    check("setup_pwdata", pwdata, cur.d);
                end
            end else if (psel && penable) begin
                check("access_stable_addr", paddr, cur.a);
                check("access_stable_wdata", pwdata, cur.d);
                check("access_stable_write", 32'(pwrite), 32'(cur.w));
            end
        end
    end

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input int exp_lat, input int exp_gap);
        int g = 0;
        rsp_t e;
        apb_t p;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && g < 200) begin
            @(negedge pclk);
            g++;
        end
        if (!req_ready) fail_now("accept_timeout");
        @(posedge pclk);
        #1;
        req_valid = 1'b0;
        e.w = w; e.err = exp_err; e.rd = exp_rd; e.lat = exp_lat; e.gap = exp_gap; e.acc = cycle;
        p.w = w; p.a = a; p.d = d;
        rsp_q.push_back(e);
        apb_q.push_back(p);
        @(negedge pclk);
    endtask

    task automatic drain();
        int g = 0;
        while ((rsp_q.size() != 0 || psel) && g < 400) begin
            @(negedge pclk);
            g++;
        end
        if (g >= 400) fail_now("drain_timeout");
        repeat (2) @(negedge pclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge pclk);
        check("rst_psel", 32'(psel), 0);
        check("rst_penable", 32'(penable), 0);
        check("rst_pwrite", 32'(pwrite), 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_rsp_write", 32'(rsp_write), 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_req_ready", 32'(req_ready), 1);
        rst_n = 1'b1;
        @(negedge pclk);

        // Write then read back 0x10, no wait states: 3 edges accept -> response.
        send(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 3, -1);
        drain();
        send(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 3, -1);
        drain();

        // Three wait states on a write to 0x20: response 3 edges later than baseline.
        send(1'b1, 32'h20, 32'hA5A5_0001, 1'b0, 32'h0, 6, -1);
        drain();

        // Slave never ready: error after 16 ACCESS cycles, queued write follows back-to-back.
        send(1'b0, 32'h30, 32'h0, 1'b1, 32'h0, 18, -1);
        send(1'b1, 32'h08, 32'h0000_0077, 1'b0, 32'h0, -1, 2);
        drain();

        // A slow write lets four reads fill the FIFO; a fifth is held until space frees.
        send(1'b1, 32'h40, 32'h0000_1234, 1'b0, 32'h0, 13, -1);
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 32'(i), 32'h0, 1'b0, 32'(i), -1, 2);
        end
        check("full_req_ready", 32'(req_ready), 0);
        send(1'b0, 32'h4, 32'h0, 1'b0, 32'h4, -1, 2);
        drain();

        // Reset during ACCESS with two requests queued: no response, FIFO discarded.
        send(1'b0, 32'h50, 32'h0, 1'b0, 32'h0, -1, -1);
        send(1'b0, 32'h1, 32'h0, 1'b0, 32'h1, -1, -1);
        send(1'b0, 32'h2, 32'h0, 1'b0, 32'h2, -1, -1);
        begin
            int g = 0;
            while (!(psel && penable) && g < 50) begin
                @(negedge pclk);
                g++;
            end
            if (!(psel && penable)) fail_now("wait_access");
        end
        rst_n = 1'b0;
        #1;
        check("midrst_psel", 32'(psel), 0);
        check("midrst_penable", 32'(penable), 0);
        check("midrst_paddr", paddr, 0);
        check("midrst_rsp_valid", 32'(rsp_valid), 0);
        check("midrst_req_ready", 32'(req_ready), 1);
        rsp_q.delete();
        apb_q.delete();
        repeat (3) @(negedge pclk);
        rst_n = 1'b1;
        repeat (10) @(negedge pclk);
        check("postrst_idle_psel", 32'(psel), 0);
        check("postrst_req_ready", 32'(req_ready), 1);

        send(1'b0, 32'h3, 32'h0, 1'b0, 32'h3, 3, -1);
        drain();
        check("leftover_rsp", 32'(rsp_q.size()), 0);
        check("leftover_apb", 32'(apb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the request FIFO depth; power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the ACCESS-phase wait-cycle limit; at least 2.
REQ-003 pclk  in  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous active-low reset.
REQ-005 req_valid / req_ready  in / out  1 / 1  SHALL form the request handshake; accept when both are 1 at a pclk edge.
REQ-006 req_write  in  1  SHALL select the request type: 1 = write, 0 = read.
REQ-007 req_addr, req_wdata  in  32 each  SHALL carry the request address and write data.
REQ-008 rsp_valid  out  1  SHALL be a one-cycle completion pulse; there is no backpressure.
REQ-009 rsp_write, rsp_err  out  1 each  SHALL give the completed type and a timeout flag.
REQ-010 rsp_rdata  out  32  SHALL carry read data, valid while rsp_valid=1.
REQ-011 paddr, pwdata  out  32 each  SHALL drive the APB address and write data.
REQ-012 psel, penable, pwrite  out  1 each  SHALL drive the APB control signals.
REQ-013 pready  in  1  SHALL be the APB wait-state input from the slave.
REQ-014 prdata  in  32  SHALL be the APB read-data input from the slave.

Function
REQ-015 Accepted requests SHALL be stored in a FIFO of {write, addr, wdata} and issued in order.
REQ-016 req_ready SHALL equal !full, registered-free; a push when full SHALL be impossible.
REQ-017 A push and pop in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-018 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an occupancy count of log2(FIFO_DEPTH)+1 bits.
REQ-019 The FSM SHALL have three states: IDLE, SETUP, ACCESS.
REQ-020 IDLE with the FIFO non-empty SHALL pop the head and go to SETUP; otherwise it stays in IDLE.
REQ-021 SETUP SHALL last one cycle with psel=1, penable=0, and paddr/pwrite/pwdata from the popped entry; then ACCESS.
REQ-022 ACCESS SHALL hold psel=1, penable=1, and all APB outputs stable until completion.
REQ-023 Completion SHALL occur at a pclk edge in ACCESS where pready=1.
REQ-024 At completion, the next cycle SHALL carry rsp_valid=1, rsp_write=pwrite, rsp_err=0.
REQ-025 At completion, rsp_rdata SHALL be the prdata sampled on a read and 0 on a write.
REQ-026 At completion, the FSM SHALL go to SETUP with the next entry popped if the FIFO is non-empty (back-to-back, no IDLE cycle); otherwise to IDLE with psel=0, penable=0.
REQ-027 A wait-cycle counter SHALL clear on SETUP entry and increment on each ACCESS edge with pready=0.
REQ-028 When the counter reaches TIMEOUT, the transfer SHALL end as at completion, but with rsp_err=1 and rsp_rdata=0.
REQ-029 paddr, pwdata and pwrite SHALL hold their last values in IDLE; psel and penable SHALL be 0 in IDLE.
REQ-030 All APB and response outputs SHALL be registered; latency from accept (empty FIFO, IDLE) to SETUP SHALL be 2 edges.
REQ-031 Minimum request-to-response latency SHALL be 4 edges with pready held at 1: accept, SETUP, ACCESS, rsp_valid.

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, FIFO empty, counter 0.
REQ-033 rst_n=0 SHALL immediately force psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
REQ-034 rst_n=0 SHALL immediately force rsp_valid=0, rsp_err=0, rsp_write=0, rsp_rdata=0; req_ready SHALL be 1 after reset.
REQ-035 Reset mid-transfer SHALL abort with no response pulse; queued requests SHALL be discarded.

Verification
REQ-036 Write 0x10 then read 0x10 with data 0xDEADBEEF, pready=1 -> two SETUP/ACCESS pairs; read rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 Push 4 reads to addresses 0..3 back-to-back -> req_ready=0 after the 4th push; APB phases run contiguously with no IDLE; rsp_rdata=0,1,2,3 in order.
REQ-038 Hold pready=0 for 3 ACCESS cycles on a write to 0x20 -> APB outputs stable; rsp_valid exactly 3 cycles later than with no waits.
REQ-039 Hold pready=0 permanently on a read -> rsp_valid with rsp_err=1 and rsp_rdata=0 after 16 ACCESS cycles; the next queued request proceeds.
REQ-040 Assert rst_n=0 during ACCESS with 2 queued requests -> psel=0 immediately, no rsp_valid, FIFO empty, req_ready=1.
REQ-041 Push while FIFO full and pop in the same cycle (req_valid held) -> the held request is accepted on the first cycle req_ready=1, with none lost or duplicated.
